// File: rtl/noc_mem_requester_pkg.sv
// Shared NoC message definitions for the DRAM requester: header flit layout, message types,
// and the requester FSM state encoding.
package noc_mem_requester_pkg;

  localparam int unsigned NOC_DATA_WIDTH      = 256;
  localparam int unsigned NOC_DATA_BYTES      = NOC_DATA_WIDTH / 8;
  localparam int unsigned NOC_DATA_BYTES_W    = $clog2(NOC_DATA_BYTES);
  localparam int unsigned MSG_ADDR_WIDTH      = 64;
  localparam int unsigned MSG_DATA_SIZE_WIDTH = 16;
  localparam int unsigned MSG_LENGTH_WIDTH    = 8;
  localparam int unsigned MSG_TYPE_WIDTH      = 8;
  localparam int unsigned MSG_CHIP_ID_WIDTH   = 14;
  localparam int unsigned MSG_COORD_WIDTH     = 8;
  localparam int unsigned MSG_FBITS_WIDTH     = 4;
  localparam int unsigned MSG_MSHRID_WIDTH    = 8;
  localparam int unsigned MSG_RSVD_WIDTH      = 84;

  localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM      = 8'd19;
  localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM     = 8'd20;
  localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_LOAD_MEM_ACK  = 8'd24;
  localparam logic [MSG_TYPE_WIDTH-1:0] MSG_TYPE_STORE_MEM_ACK = 8'd25;

  // Field order is MSB first on the wire; total is exactly one NoC flit.
  typedef struct packed {
    logic [MSG_CHIP_ID_WIDTH-1:0]   dst_chip_id;
    logic [MSG_COORD_WIDTH-1:0]     dst_x_coord;
    logic [MSG_COORD_WIDTH-1:0]     dst_y_coord;
    logic [MSG_FBITS_WIDTH-1:0]     dst_fbits;
    logic [MSG_LENGTH_WIDTH-1:0]    msg_len;
    logic [MSG_TYPE_WIDTH-1:0]      msg_type;
    logic [MSG_MSHRID_WIDTH-1:0]    msg_mshrid;
    logic [MSG_ADDR_WIDTH-1:0]      addr;
    logic [MSG_DATA_SIZE_WIDTH-1:0] data_size;
    logic [MSG_CHIP_ID_WIDTH-1:0]   src_chip_id;
    logic [MSG_COORD_WIDTH-1:0]     src_x_coord;
    logic [MSG_COORD_WIDTH-1:0]     src_y_coord;
    logic [MSG_FBITS_WIDTH-1:0]     src_fbits;
    logic [MSG_RSVD_WIDTH-1:0]      rsvd;
  } noc_hdr_flit;

  typedef enum logic [2:0] {
    IDLE,
    REQ_HDR,
    ST_DATA,
    RESP_HDR,
    RD_DATA
  } state_e;

  // Number of flits needed to carry size bytes (rounded up).
  function automatic logic [MSG_LENGTH_WIDTH-1:0] calc_flit_cnt(
    input logic [MSG_DATA_SIZE_WIDTH-1:0] size
  );
    logic [MSG_DATA_SIZE_WIDTH-1:0] q;
    q = size >> NOC_DATA_BYTES_W;
    if (size[NOC_DATA_BYTES_W-1:0] != '0) begin
      q = q + MSG_DATA_SIZE_WIDTH'(1);
    end
    return q[MSG_LENGTH_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/noc_mem_req_hdr_gen.sv
// Combinational request-header builder: turns the registered command plus tile/controller
// coordinates into a LOAD_MEM or STORE_MEM header flit.
module noc_mem_req_hdr_gen
  import noc_mem_requester_pkg::*;
#(
  parameter logic [MSG_COORD_WIDTH-1:0] SRC_X     = '0,
  parameter logic [MSG_COORD_WIDTH-1:0] SRC_Y     = '0,
  parameter logic [MSG_COORD_WIDTH-1:0] DST_X     = '0,
  parameter logic [MSG_COORD_WIDTH-1:0] DST_Y     = '0,
  parameter logic [MSG_FBITS_WIDTH-1:0] SRC_FBITS = '0
) (
  input  logic                           write_i,
  input  logic [MSG_ADDR_WIDTH-1:0]      addr_i,
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] size_i,
  output logic [NOC_DATA_WIDTH-1:0]      hdr_o,
  output logic [MSG_LENGTH_WIDTH-1:0]    flit_cnt_o
);

  noc_hdr_flit hdr;

  always_comb begin
    flit_cnt_o      = calc_flit_cnt(size_i);
    hdr             = '0;
    hdr.dst_x_coord = DST_X;
    hdr.dst_y_coord = DST_Y;
    hdr.src_x_coord = SRC_X;
    hdr.src_y_coord = SRC_Y;
    hdr.src_fbits   = SRC_FBITS;
    hdr.addr        = addr_i;
    hdr.data_size   = size_i;
    if (write_i) begin
      hdr.msg_type = MSG_TYPE_STORE_MEM;
      hdr.msg_len  = flit_cnt_o;
    end else begin
      hdr.msg_type = MSG_TYPE_LOAD_MEM;
      hdr.msg_len  = '0;
    end
    hdr_o = hdr;
  end

endmodule

// File: rtl/noc_mem_requester.sv
// NoC initiator for the DRAM controller: issues one LOAD_MEM/STORE_MEM at a time on noc0 and
// returns load data or a store completion to the local engine.
module noc_mem_requester
  import noc_mem_requester_pkg::*;
#(
  parameter logic [MSG_COORD_WIDTH-1:0] SRC_X     = '0,
  parameter logic [MSG_COORD_WIDTH-1:0] SRC_Y     = '0,
  parameter logic [MSG_COORD_WIDTH-1:0] DST_X     = '0,
  parameter logic [MSG_COORD_WIDTH-1:0] DST_Y     = '0,
  parameter logic [MSG_FBITS_WIDTH-1:0] SRC_FBITS = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_val,
  input  logic                           req_write,
  input  logic [MSG_ADDR_WIDTH-1:0]      req_addr,
  input  logic [MSG_DATA_SIZE_WIDTH-1:0] req_size,
  output logic                           req_rdy,
  input  logic                           wr_data_val,
  input  logic [NOC_DATA_WIDTH-1:0]      wr_data,
  output logic                           wr_data_rdy,
  output logic                           rd_data_val,
  output logic [NOC_DATA_WIDTH-1:0]      rd_data,
  output logic                           rd_data_last,
  input  logic                           rd_data_rdy,
  output logic                           wr_done,
  output logic                           resp_err,
  output logic                           requester_noc0_vrtoc_val,
  output logic [NOC_DATA_WIDTH-1:0]      requester_noc0_vrtoc_data,
  input  logic                           noc0_vrtoc_requester_rdy,
  input  logic                           noc0_ctovr_requester_val,
  input  logic [NOC_DATA_WIDTH-1:0]      noc0_ctovr_requester_data,
  output logic                           requester_noc0_ctovr_rdy
);

  state_e                         state_q, state_d;
  logic                           write_q, write_d;
  logic [MSG_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [MSG_DATA_SIZE_WIDTH-1:0] size_q, size_d;
  logic [MSG_LENGTH_WIDTH-1:0]    cnt_q, cnt_d;
  logic [MSG_LENGTH_WIDTH-1:0]    rd_len_q, rd_len_d;
  logic                           wr_done_q, wr_done_d;
  logic                           resp_err_q, resp_err_d;
  // Keeps req_rdy low while reset is asserted even though IDLE is the reset state.
  logic                           alive_q;

  logic [NOC_DATA_WIDTH-1:0]      hdr;
  logic [MSG_LENGTH_WIDTH-1:0]    flit_cnt;
  noc_hdr_flit                    resp_hdr;
  logic                           rd_last;

  noc_mem_req_hdr_gen #(
    .SRC_X     (SRC_X),
    .SRC_Y     (SRC_Y),
    .DST_X     (DST_X),
    .DST_Y     (DST_Y),
    .SRC_FBITS (SRC_FBITS)
  ) u_hdr_gen (
    .write_i    (write_q),
    .addr_i     (addr_q),
    .size_i     (size_q),
    .hdr_o      (hdr),
    .flit_cnt_o (flit_cnt)
  );

  assign resp_hdr = noc_hdr_flit'(noc0_ctovr_requester_data);
  assign rd_last  = (cnt_q == rd_len_q - MSG_LENGTH_WIDTH'(1));
  assign wr_done  = wr_done_q;
  assign resp_err = resp_err_q;

  always_comb begin
    state_d                   = state_q;
    write_d                   = write_q;
    addr_d                    = addr_q;
    size_d                    = size_q;
    cnt_d                     = cnt_q;
    rd_len_d                  = rd_len_q;
    wr_done_d                 = 1'b0;
    resp_err_d                = resp_err_q;
    req_rdy                   = 1'b0;
    wr_data_rdy               = 1'b0;
    rd_data_val               = 1'b0;
    rd_data                   = '0;
    rd_data_last              = 1'b0;
    requester_noc0_vrtoc_val  = 1'b0;
    requester_noc0_vrtoc_data = '0;
    requester_noc0_ctovr_rdy  = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_rdy = alive_q;
        if (req_val && alive_q) begin
          write_d = req_write;
          addr_d  = req_addr;
          size_d  = req_size;
          if (req_size == '0) begin
            wr_done_d = req_write;
          end else begin
            state_d = REQ_HDR;
          end
        end
      end

      REQ_HDR: begin
        requester_noc0_vrtoc_val  = 1'b1;
        requester_noc0_vrtoc_data = hdr;
        if (noc0_vrtoc_requester_rdy) begin
          if (write_q) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end else begin
            state_d = RESP_HDR;
          end
        end
      end

      ST_DATA: begin
        requester_noc0_vrtoc_val  = wr_data_val;
        requester_noc0_vrtoc_data = wr_data;
        wr_data_rdy               = noc0_vrtoc_requester_rdy;
        if (wr_data_val && noc0_vrtoc_requester_rdy) begin
          cnt_d = cnt_q + MSG_LENGTH_WIDTH'(1);
          if (cnt_q == flit_cnt - MSG_LENGTH_WIDTH'(1)) begin
            state_d = RESP_HDR;
          end
        end
      end

      RESP_HDR: begin
        requester_noc0_ctovr_rdy = 1'b1;
        if (noc0_ctovr_requester_val) begin
          if (write_q && resp_hdr.msg_type == MSG_TYPE_STORE_MEM_ACK) begin
            wr_done_d = 1'b1;
            state_d   = IDLE;
          end else if (!write_q && resp_hdr.msg_type == MSG_TYPE_LOAD_MEM_ACK) begin
            rd_len_d = resp_hdr.msg_len;
            cnt_d    = '0;
            state_d  = (resp_hdr.msg_len == '0) ? IDLE : RD_DATA;
          end else begin
            resp_err_d = 1'b1;
          end
        end
      end

      RD_DATA: begin
        rd_data_val              = noc0_ctovr_requester_val;
        rd_data                  = noc0_ctovr_requester_data;
        rd_data_last             = rd_last;
        requester_noc0_ctovr_rdy = rd_data_rdy;
        if (noc0_ctovr_requester_val && rd_data_rdy) begin
          cnt_d = cnt_q + MSG_LENGTH_WIDTH'(1);
          if (rd_last) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      rd_len_q   <= '0;
      wr_done_q  <= 1'b0;
      resp_err_q <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      rd_len_q   <= rd_len_d;
      wr_done_q  <= wr_done_d;
      resp_err_q <= resp_err_d;
      alive_q    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_mem_requester.sv
// Directed bench for noc_mem_requester: store, load, back-pressured load, wrong ack,
// zero-size commands and reset in the middle of a store.
module tb_noc_mem_requester;
  import noc_mem_requester_pkg::*;

  localparam logic [7:0] TB_SRC_X = 8'd1;
  localparam logic [7:0] TB_SRC_Y = 8'd2;
  localparam logic [7:0] TB_DST_X = 8'd3;
  localparam logic [7:0] TB_DST_Y = 8'd4;
  localparam logic [3:0] TB_FBITS = 4'hA;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic                           req_val, req_write, req_rdy;
  logic [MSG_ADDR_WIDTH-1:0]      req_addr;
  logic [MSG_DATA_SIZE_WIDTH-1:0] req_size;
  logic                           wr_data_val, wr_data_rdy;
  logic [NOC_DATA_WIDTH-1:0]      wr_data;
  logic                           rd_data_val, rd_data_last, rd_data_rdy;
  logic [NOC_DATA_WIDTH-1:0]      rd_data;
  logic                           wr_done, resp_err;
  logic                           vrtoc_val, vrtoc_rdy, ctovr_val, ctovr_rdy;
  logic [NOC_DATA_WIDTH-1:0]      vrtoc_data, ctovr_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  noc_mem_requester #(
    .SRC_X     (TB_SRC_X),
    .SRC_Y     (TB_SRC_Y),
    .DST_X     (TB_DST_X),
    .DST_Y     (TB_DST_Y),
    .SRC_FBITS (TB_FBITS)
  ) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .req_val                   (req_val),
    .req_write                 (req_write),
    .req_addr                  (req_addr),
    .req_size                  (req_size),
    .req_rdy                   (req_rdy),
    .wr_data_val               (wr_data_val),
    .wr_data                   (wr_data),
    .wr_data_rdy               (wr_data_rdy),
    .rd_data_val               (rd_data_val),
    .rd_data                   (rd_data),
    .rd_data_last              (rd_data_last),
    .rd_data_rdy               (rd_data_rdy),
    .wr_done                   (wr_done),
    .resp_err                  (resp_err),
    .requester_noc0_vrtoc_val  (vrtoc_val),
    .requester_noc0_vrtoc_data (vrtoc_data),
    .noc0_vrtoc_requester_rdy  (vrtoc_rdy),
    .noc0_ctovr_requester_val  (ctovr_val),
    .noc0_ctovr_requester_data (ctovr_data),
    .requester_noc0_ctovr_rdy  (ctovr_rdy)
  );

  task automatic check_eq(input string tag, input logic [NOC_DATA_WIDTH-1:0] obs,
                          input logic [NOC_DATA_WIDTH-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NOC_DATA_WIDTH-1:0] mk_req_hdr(
    input logic [7:0] mtype, input logic [7:0] len, input logic [63:0] addr,
    input logic [15:0] size);
    noc_hdr_flit h;
    h             = '0;
    h.dst_x_coord = 8'd3;
    h.dst_y_coord = 8'd4;
    h.src_x_coord = 8'd1;
    h.src_y_coord = 8'd2;
    h.src_fbits   = 4'hA;
    h.msg_type    = mtype;
    h.msg_len     = len;
    h.addr        = addr;
    h.data_size   = size;
    return h;
  endfunction

  function automatic logic [NOC_DATA_WIDTH-1:0] mk_ack(input logic [7:0] mtype,
                                                        input logic [7:0] len);
    noc_hdr_flit h;
    h          = '0;
    h.msg_type = mtype;
    h.msg_len  = len;
    h.dst_x_coord = 8'd1;
    h.dst_y_coord = 8'd2;
    return h;
  endfunction

  function automatic logic [NOC_DATA_WIDTH-1:0] pat(input int k);
    return {8{k[7:0] + 8'h11, 8'hC3, k[7:0], 8'h5A}};
  endfunction

  task automatic issue(input logic wr, input logic [63:0] addr, input logic [15:0] size);
    req_val   = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_size  = size;
    #1;
    check_eq("issue_req_rdy", req_rdy, 1);
    cyc();
    req_val = 1'b0;
  endtask

  initial begin
    logic [NOC_DATA_WIDTH-1:0] flits [3];
    int k;
    logic rdy_now;

    rst_n       = 1'b0;
    req_val     = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_size    = '0;
    wr_data_val = 1'b0;
    wr_data     = '0;
    rd_data_rdy = 1'b0;
    vrtoc_rdy   = 1'b1;
    ctovr_val   = 1'b0;
    ctovr_data  = '0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_rdy", req_rdy, 0);
    check_eq("rst_vrtoc_val", vrtoc_val, 0);
    check_eq("rst_wr_done", wr_done, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_rd_last", rd_data_last, 0);
    check_eq("rst_ctovr_rdy", ctovr_rdy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check_eq("post_rst_req_rdy", req_rdy, 1);

    // Store 64 bytes at 0x40: header then two data flits
    issue(1'b1, 64'h40, 16'd64);
    check_eq("st_hdr_val", vrtoc_val, 1);
    check_eq("st_hdr_data", vrtoc_data, mk_req_hdr(MSG_TYPE_STORE_MEM, 8'd2, 64'h40, 16'd64));
    check_eq("st_hdr_req_rdy", req_rdy, 0);
    check_eq("st_hdr_wr_rdy", wr_data_rdy, 0);
    cyc();
    wr_data_val = 1'b1;
    wr_data     = pat(1);
    #1;
    check_eq("st_d0_data", vrtoc_data, pat(1));
    check_eq("st_d0_wr_rdy", wr_data_rdy, 1);
    cyc();
    wr_data = pat(2);
    #1;
    check_eq("st_d1_data", vrtoc_data, pat(2));
    check_eq("st_d1_wr_rdy", wr_data_rdy, 1);
    cyc();
    #1;
    check_eq("st_resp_wr_rdy", wr_data_rdy, 0);
    check_eq("st_resp_vrtoc_val", vrtoc_val, 0);
    wr_data_val = 1'b0;
    ctovr_val   = 1'b1;
    ctovr_data  = mk_ack(MSG_TYPE_STORE_MEM_ACK, 8'd0);
    #1;
    check_eq("st_resp_ctovr_rdy", ctovr_rdy, 1);
    check_eq("st_wr_done_early", wr_done, 0);
    cyc();
    ctovr_val = 1'b0;
    #1;
    check_eq("st_wr_done", wr_done, 1);
    check_eq("st_idle_req_rdy", req_rdy, 1);
    cyc();
    check_eq("st_wr_done_once", wr_done, 0);

    // Load 40 bytes at 0x1010, ack with two data flits
    issue(1'b0, 64'h1010, 16'd40);
    check_eq("ld_hdr_data", vrtoc_data, mk_req_hdr(MSG_TYPE_LOAD_MEM, 8'd0, 64'h1010, 16'd40));
    cyc();
    check_eq("ld_resp_vrtoc_val", vrtoc_val, 0);
    rd_data_rdy = 1'b1;
    ctovr_val   = 1'b1;
    ctovr_data  = mk_ack(MSG_TYPE_LOAD_MEM_ACK, 8'd2);
    #1;
    check_eq("ld_ack_rd_val", rd_data_val, 0);
    cyc();
    ctovr_data = pat(10);
    #1;
    check_eq("ld_d0_val", rd_data_val, 1);
    check_eq("ld_d0_data", rd_data, pat(10));
    check_eq("ld_d0_last", rd_data_last, 0);
    cyc();
    ctovr_data = pat(11);
    #1;
    check_eq("ld_d1_val", rd_data_val, 1);
    check_eq("ld_d1_data", rd_data, pat(11));
    check_eq("ld_d1_last", rd_data_last, 1);
    cyc();
    ctovr_val = 1'b0;
    #1;
    check_eq("ld_done_req_rdy", req_rdy, 1);
    check_eq("ld_done_rd_val", rd_data_val, 0);
    check_eq("ld_no_wr_done", wr_done, 0);

    // Load with a consumer that is ready every other cycle
    flits[0] = pat(20);
    flits[1] = pat(21);
    flits[2] = pat(22);
    issue(1'b0, 64'h2000, 16'd96);
    cyc();
    rd_data_rdy = 1'b1;
    ctovr_val   = 1'b1;
    ctovr_data  = mk_ack(MSG_TYPE_LOAD_MEM_ACK, 8'd3);
    cyc();
    k = 0;
    for (int i = 0; i < 6; i++) begin
      rdy_now     = (i % 2 == 1);
      rd_data_rdy = rdy_now;
      ctovr_data  = flits[k];
      #1;
      check_eq("bp_ctovr_rdy", ctovr_rdy, rdy_now);
      check_eq("bp_rd_data", rd_data, flits[k]);
      check_eq("bp_rd_last", rd_data_last, (k == 2));
      cyc();
      if (rdy_now) k++;
    end
    ctovr_val   = 1'b0;
    rd_data_rdy = 1'b0;
    #1;
    check_eq("bp_done_req_rdy", req_rdy, 1);

    // Store of one flit answered first by the wrong ack type
    issue(1'b1, 64'h80, 16'd32);
    cyc();
    wr_data_val = 1'b1;
    wr_data     = pat(30);
    cyc();
    wr_data_val = 1'b0;
    ctovr_val   = 1'b1;
    ctovr_data  = mk_ack(MSG_TYPE_LOAD_MEM_ACK, 8'd1);
    cyc();
    #1;
    check_eq("werr_resp_err", resp_err, 1);
    check_eq("werr_no_wr_done", wr_done, 0);
    check_eq("werr_still_wait", ctovr_rdy, 1);
    check_eq("werr_req_rdy", req_rdy, 0);
    ctovr_data = mk_ack(MSG_TYPE_STORE_MEM_ACK, 8'd0);
    cyc();
    ctovr_val = 1'b0;
    #1;
    check_eq("werr_wr_done", wr_done, 1);
    check_eq("werr_req_rdy_back", req_rdy, 1);
    check_eq("werr_err_sticky", resp_err, 1);

    // Zero-size store completes without NoC traffic; zero-size load does nothing
    cyc();
    req_val   = 1'b1;
    req_write = 1'b1;
    req_size  = '0;
    #1;
    check_eq("z_st_vrtoc_val", vrtoc_val, 0);
    cyc();
    req_val = 1'b0;
    #1;
    check_eq("z_st_wr_done", wr_done, 1);
    check_eq("z_st_req_rdy", req_rdy, 1);
    check_eq("z_st_vrtoc_val2", vrtoc_val, 0);
    req_val   = 1'b1;
    req_write = 1'b0;
    cyc();
    req_val = 1'b0;
    #1;
    check_eq("z_ld_wr_done", wr_done, 0);
    check_eq("z_ld_req_rdy", req_rdy, 1);

    // Reset in the middle of a three-flit store
    issue(1'b1, 64'hC0, 16'd96);
    cyc();
    wr_data_val = 1'b1;
    wr_data     = pat(40);
    cyc();
    wr_data = pat(41);
    #1;
    check_eq("mr_pre_vrtoc_val", vrtoc_val, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mr_vrtoc_val", vrtoc_val, 0);
    check_eq("mr_wr_data_rdy", wr_data_rdy, 0);
    check_eq("mr_req_rdy", req_rdy, 0);
    check_eq("mr_resp_err", resp_err, 0);
    @(negedge clk);
    wr_data_val = 1'b0;
    rst_n       = 1'b1;
    cyc();
    check_eq("mr_req_rdy_after", req_rdy, 1);
    check_eq("mr_vrtoc_after", vrtoc_val, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
